// File: rtl/jk_down_timer.sv
// Loadable down-counter/timer whose count bits are individual JK flops on one clock.
// One-shot stops at zero; auto-reload restarts from the last loaded value on expiry.
module jk_down_timer #(
  parameter int unsigned WIDTH       = 4,
  parameter int unsigned AUTO_RELOAD = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             pause,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             zero,
  output logic             done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] reload_reg;
  logic [WIDTH-1:0] j, k;
  logic             advance, expire, reload_now, borrow;

  // An advancing RUN edge either decrements or, at count 1, expires.
  always_comb begin
    advance    = (state == RUN) && !load && !pause && !zero;
    expire     = advance && (count == WIDTH'(1));
    reload_now = expire && (AUTO_RELOAD != 0);
  end

  // Bit i toggles on decrement only when all lower bits are 0 (borrow chain).
  always_comb begin
    j      = '0;
    k      = '0;
    borrow = 1'b1;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (load) begin
        j[i] = load_val[i];
        k[i] = ~load_val[i];
      end else if (reload_now) begin
        j[i] = reload_reg[i];
        k[i] = ~reload_reg[i];
      end else if (advance) begin
        j[i] = borrow;
        k[i] = borrow;
      end
      borrow = borrow & ~count[i];
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (reset) begin
        count[i] <= 1'b0;
      end else begin
        case ({j[i], k[i]})
          2'b01:   count[i] <= 1'b0;
          2'b10:   count[i] <= 1'b1;
          2'b11:   count[i] <= ~count[i];
          default: count[i] <= count[i];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      reload_reg <= '0;
      done       <= 1'b0;
    end else begin
      if (load) reload_reg <= load_val;
      done <= expire;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (!load && start && !zero) state_next = RUN;
      RUN: begin
        if (load)                                 state_next = IDLE;
        else if (expire && (AUTO_RELOAD == 0))    state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    zero = (count == '0);
  end

endmodule
